// File: rtl/sumsq_accum.sv
// Streaming sum-of-squares accumulator: one signed element per cycle in, one
// registered (sum, id, length, saturated) result pulse out per completed vector.
module sumsq_accum #(
  parameter int id_width   = 20,
  parameter int data_width = 16,
  parameter int len_width  = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         valid_in,
  input  logic signed [data_width-1:0] x_in,
  input  logic                         last_in,
  input  logic        [id_width-1:0]   vec_id,
  output logic        [31:0]           dot_sum,
  output logic        [id_width-1:0]   id_out,
  output logic        [len_width-1:0]  len_out,
  output logic                         sat_out,
  output logic                         valid_out
);

  // state | meaning
  // START | next accepted element is the first element of a new vector
  // MID   | inside a vector, at least one non-last element accepted
  typedef enum logic {START, MID} state_t;

  localparam logic [31:0]          sum_max = 32'h7FFF_FFFF;
  localparam logic [len_width-1:0] len_max = '1;

  state_t state, state_next;

  logic                         s1_valid, s1_last, s1_first;
  logic signed [data_width-1:0] s1_x;
  logic        [id_width-1:0]   s1_id;

  logic                         s2_valid, s2_last, s2_first;
  logic        [31:0]           s2_sq;
  logic        [id_width-1:0]   s2_id;

  logic        [31:0]           acc;
  logic        [len_width-1:0]  cnt;
  logic                         sat;
  logic        [id_width-1:0]   acc_id;
  logic                         s3_done;

  logic signed [2*data_width-1:0] sq_full;
  logic        [31:0]             base_acc, acc_next;
  logic        [32:0]             sum33;
  logic        [len_width-1:0]    base_cnt, cnt_next;
  logic                           base_sat, sat_next, over;
  logic        [id_width-1:0]     id_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= START;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (valid_in) state_next = last_in ? START : MID;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_x     <= '0;
      s1_id    <= '0;
    end else begin
      s1_valid <= valid_in;
      s1_last  <= last_in;
      s1_first <= (state == START);
      s1_x     <= x_in;
      s1_id    <= vec_id;
    end
  end

  // A square of a signed value is never negative, so zero-extension is exact.
  assign sq_full = s1_x * s1_x;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_first <= 1'b0;
      s2_sq    <= '0;
      s2_id    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_first <= s1_first;
      s2_sq    <= 32'($unsigned(sq_full));
      s2_id    <= s1_id;
    end
  end

  // The first-element flag restarts the running values in place, so a vector
  // arriving right behind another never disturbs the result being unloaded.
  always_comb begin
    base_acc = s2_first ? 32'd0 : acc;
    base_cnt = s2_first ? '0 : cnt;
    base_sat = s2_first ? 1'b0 : sat;
    id_next  = s2_first ? s2_id : acc_id;
    sum33    = {1'b0, base_acc} + {1'b0, s2_sq};
    over     = sum33[32] | sum33[31];
    acc_next = over ? sum_max : sum33[31:0];
    sat_next = base_sat | over;
    cnt_next = (base_cnt == len_max) ? base_cnt : base_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc     <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
      acc_id  <= '0;
      s3_done <= 1'b0;
    end else begin
      s3_done <= s2_valid & s2_last;
      if (s2_valid) begin
        acc    <= acc_next;
        cnt    <= cnt_next;
        sat    <= sat_next;
        acc_id <= id_next;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_out <= 1'b0;
      dot_sum   <= '0;
      id_out    <= '0;
      len_out   <= '0;
      sat_out   <= 1'b0;
    end else begin
      valid_out <= s3_done;
      if (s3_done) begin
        dot_sum <= acc;
        id_out  <= acc_id;
        len_out <= cnt;
        sat_out <= sat;
      end
    end
  end

endmodule

// File: doc/sumsq_accum.md
# sumsq_accum

Streaming sum-of-squares accumulator that produces the per-vector `dot_sum`/`vec_id`/`valid_in` triple consumed by the normalization stage (fixed-to-float conversion followed by inverse square root). It accepts one signed fixed-point vector element per cycle, with a last-element marker. For each element it squares the value and accumulates into a 32-bit saturating sum. When a vector completes, it emits a single-cycle result pulse tagged with the vector's ID. It has no backpressure and sustains back-to-back vectors at full element rate.

## Interface
- `id_width`, default 20: vector ID width; must match the normalization stage.
- `data_width`, default 16: signed element width; legal range 2..16, so that a square fits in 31 bits.
- `len_width`, default 16: element-count output width.
- `clk`  in  1: single clock. All logic is rising-edge.
- `nrst`  in  1: reset, asynchronous, active-low.
- `valid_in`  in  1: the element on `x_in` is valid this cycle and is always accepted.
- `x_in`  in  `data_width`: signed element value.
- `last_in`  in  1: qualified by `valid_in`; marks the final element of a vector.
- `vec_id`  in  `id_width`: vector ID; sampled only on the first element of each vector.
- `dot_sum`  out  32: signed sum of squares, saturated to 0x7FFF_FFFF.
- `id_out`  out  `id_width`: ID of the completed vector.
- `len_out`  out  `len_width`: element count of the completed vector; saturates at all-ones.
- `sat_out`  out  1: the accumulation saturated at some point in this vector.
- `valid_out`  out  1: one-cycle pulse; qualifies `dot_sum`, `id_out`, `len_out` and `sat_out`.

## Operation
- Vector framing uses a 1-bit state, START or MID.
  - Reset state is START.
  - Any accepted element with `last_in`=0 moves the state to MID.
  - Any accepted element with `last_in`=1 moves the state to START.
  - Cycles with `valid_in`=0 hold the state, so gaps inside a vector are legal and invisible.
- An element accepted in START is the first element of a vector. On that element:
  - the accumulator, count and saturation flag restart;
  - `vec_id` is captured.
- `vec_id` on non-first elements is ignored.
- A single element with `last_in`=1 accepted in START is a complete 1-element vector.
- Arithmetic:
  - square is `x_in` times `x_in`, signed, `2*data_width` bits, always non-negative;
  - the largest square is 2^(2*data_width-2), i.e. 2^30 at width 16;
  - the sum is computed 33 bits wide; if it exceeds 0x7FFF_FFFF, the accumulator holds 0x7FFF_FFFF and the sticky `sat` is set for the rest of the vector;
  - once saturated, later squares do not change the value.
- The count starts at 1 on the first element, increments per element, and saturates at 2^`len_width`-1.
- Outputs are registered.
  - `dot_sum`, `id_out`, `len_out` and `sat_out` update only when `valid_out` fires, and hold their value otherwise.
  - `valid_out` is high for exactly one cycle per completed vector.
- Reset, at any time including mid-vector:
  - all pipeline valids clear and the state returns to START;
  - in-flight partial vectors are discarded with no output pulse;
  - every output resets to 0.

## Timing
- Pipeline stages:
  - S1 registers `x_in`, `valid_in`, `last_in`, the first-element flag and `vec_id`;
  - S2 registers the square;
  - S3 performs the accumulate/saturate update and loads the output registers.
- Latency: an element with `last_in`=1 sampled at edge N gives `valid_out`=1 in the cycle after edge N+3, with the final values on all outputs.
- Throughput is one element per cycle.
- Back-to-back vectors: the first element of vector B may arrive in the cycle directly after A's last element.
  - The restart of the S3 accumulator must use B's first-flag, not a separate clear, so A's result is not corrupted.
  - Two consecutive 1-element vectors produce `valid_out` on two consecutive cycles.
- The minimum spacing between `valid_out` pulses is 1 cycle.

## Test plan
- Vector [3, 4] with ID 0x5, `last_in` on the second element (sampled edge N) -> `valid_out` pulse after edge N+3; `dot_sum`=25, `id_out`=0x5, `len_out`=2, `sat_out`=0.
- Single element -32768 with `last_in`=1, ID 0xABCDE -> `dot_sum`=0x4000_0000, `len_out`=1, `sat_out`=0.
- Three elements of -32768 -> `dot_sum`=0x7FFF_FFFF, `sat_out`=1, `len_out`=3. A following vector [2] -> `dot_sum`=4, `sat_out`=0.
- Back-to-back vectors, no gap: [1, 2] ID 1 then [5] ID 2 -> two pulses on consecutive cycles, carrying (5, ID 1, len 2) then (25, ID 2, len 1).
- Vector [1, 1, 1] with 2 idle cycles between elements, and `vec_id` changed to 9 on the later elements while ID was 7 at start -> `dot_sum`=3, `id_out`=7, `len_out`=3.
- Elements [10, 10] without last, then `nrst` asserted for 1 cycle, then [2] with last -> all outputs 0 during reset, no pulse for the partial vector; the next pulse carries `dot_sum`=4, `len_out`=1.
